// File: rtl/csr_access_unit.sv
// CSR commit unit: sequences csrrd/csrwr/csrxchg, ertn and traps against the CSR file.
// Optional privilege check on CSR ops and ertn is enabled by defining CSR_PRIV_CHECK_EN.
module csr_access_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [13:0] req_csr_num,
  input  logic [31:0] req_rd_value,
  input  logic [31:0] req_rj_value,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_vaddr,
  input  logic        req_ex,
  input  logic [5:0]  req_ecode,
  input  logic [8:0]  req_esubcode,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  input  logic [12:0] csr_estat_is,
  input  logic [12:0] csr_ecfg_lie,
  input  logic        csr_crmd_ie,
  input  logic [1:0]  csr_crmd_plv,
  input  logic [31:0] csr_era,
  input  logic [31:0] csr_eentry,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rd_wdata,
  output logic        flush,
  output logic [31:0] flush_target
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_RD    = 3'd1;
  localparam logic [2:0] OP_WR    = 3'd2;
  localparam logic [2:0] OP_XCHG  = 3'd3;
  localparam logic [2:0] OP_ERTN  = 3'd4;
  localparam logic [2:0] OP_SYS   = 3'd5;
  localparam logic [2:0] OP_BRK   = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_SYS = 6'h0B;
  localparam logic [5:0] ECODE_BRK = 6'h0C;
  localparam logic [5:0] ECODE_INE = 6'h0D;
`ifdef CSR_PRIV_CHECK_EN
  localparam logic [5:0] ECODE_IPE = 6'h0E;
`endif

  typedef enum logic [1:0] {IDLE, ACT, RESP, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [2:0]  lat_op, lat_op_nxt;
  logic        lat_trap, lat_trap_nxt;
  logic        req_ready_nxt, csr_re_nxt, csr_we_nxt, wb_ex_nxt, ertn_flush_nxt;
  logic        resp_valid_nxt, flush_nxt;
  logic [13:0] csr_num_nxt;
  logic [31:0] csr_wmask_nxt, csr_wvalue_nxt, wb_pc_nxt, wb_vaddr_nxt;
  logic [31:0] resp_rd_wdata_nxt, flush_target_nxt;
  logic [5:0]  wb_ecode_nxt;
  logic [8:0]  wb_esubcode_nxt;

  logic        transfer, int_now, dec_trap;
  logic [5:0]  dec_ecode;
  logic [8:0]  dec_esub;

  assign transfer = req_valid & req_ready;
  assign int_now  = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));

  // Trap decode of the incoming request, evaluated at transfer time
  always_comb begin
    dec_trap  = 1'b1;
    dec_ecode = ECODE_INT;
    dec_esub  = 9'd0;
    if (int_now) begin
      dec_ecode = ECODE_INT;
    end else if (req_ex) begin
      dec_ecode = req_ecode;
      dec_esub  = req_esubcode;
`ifdef CSR_PRIV_CHECK_EN
    end else if ((req_op == OP_RD || req_op == OP_WR || req_op == OP_XCHG ||
                  req_op == OP_ERTN) && csr_crmd_plv != 2'd0) begin
      dec_ecode = ECODE_IPE;
`endif
    end else if (req_op == OP_RSVD) begin
      dec_ecode = ECODE_INE;
    end else if (req_op == OP_SYS) begin
      dec_ecode = ECODE_SYS;
    end else if (req_op == OP_BRK) begin
      dec_ecode = ECODE_BRK;
    end else begin
      dec_trap = 1'b0;
    end
  end

`ifndef CSR_PRIV_CHECK_EN
  logic unused_plv;
  assign unused_plv = ^csr_crmd_plv;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_nxt         = state;
    lat_op_nxt        = lat_op;
    lat_trap_nxt      = lat_trap;
    csr_re_nxt        = 1'b0;
    csr_we_nxt        = 1'b0;
    csr_num_nxt       = 14'd0;
    csr_wmask_nxt     = 32'd0;
    csr_wvalue_nxt    = 32'd0;
    wb_ex_nxt         = 1'b0;
    wb_ecode_nxt      = 6'd0;
    wb_esubcode_nxt   = 9'd0;
    wb_pc_nxt         = 32'd0;
    wb_vaddr_nxt      = 32'd0;
    ertn_flush_nxt    = 1'b0;
    resp_valid_nxt    = 1'b0;
    resp_rd_wdata_nxt = resp_rd_wdata;
    flush_nxt         = 1'b0;
    flush_target_nxt  = 32'd0;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_nxt    = ACT;
          lat_op_nxt   = req_op;
          lat_trap_nxt = dec_trap;
          if (dec_trap) begin
            wb_ex_nxt       = 1'b1;
            wb_ecode_nxt    = dec_ecode;
            wb_esubcode_nxt = dec_esub;
            wb_pc_nxt       = req_pc;
            wb_vaddr_nxt    = req_vaddr;
          end else begin
            case (req_op)
              OP_RD: begin
                csr_re_nxt  = 1'b1;
                csr_num_nxt = req_csr_num;
              end
              OP_WR, OP_XCHG: begin
                csr_re_nxt     = 1'b1;
                csr_we_nxt     = 1'b1;
                csr_num_nxt    = req_csr_num;
                csr_wmask_nxt  = (req_op == OP_WR) ? 32'hFFFF_FFFF : req_rj_value;
                csr_wvalue_nxt = req_rd_value;
              end
              OP_ERTN: ertn_flush_nxt = 1'b1;
              default: ;
            endcase
          end
        end
      end
      ACT: begin
        if (lat_trap) begin
          state_nxt        = FLUSH;
          flush_nxt        = 1'b1;
          flush_target_nxt = csr_eentry;
        end else begin
          case (lat_op)
            OP_RD, OP_WR, OP_XCHG: begin
              state_nxt         = RESP;
              resp_valid_nxt    = 1'b1;
              resp_rd_wdata_nxt = csr_rvalue;
            end
            OP_ERTN: begin
              state_nxt        = FLUSH;
              flush_nxt        = 1'b1;
              flush_target_nxt = csr_era;
            end
            default: state_nxt = IDLE;
          endcase
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
        else            resp_valid_nxt = 1'b1;
      end
      FLUSH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    req_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lat_op        <= OP_NOP;
      lat_trap      <= 1'b0;
      req_ready     <= 1'b0;
      csr_re        <= 1'b0;
      csr_we        <= 1'b0;
      csr_num       <= 14'd0;
      csr_wmask     <= 32'd0;
      csr_wvalue    <= 32'd0;
      wb_ex         <= 1'b0;
      wb_ecode      <= 6'd0;
      wb_esubcode   <= 9'd0;
      wb_pc         <= 32'd0;
      wb_vaddr      <= 32'd0;
      ertn_flush    <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rd_wdata <= 32'd0;
      flush         <= 1'b0;
      flush_target  <= 32'd0;
    end else begin
      lat_op        <= lat_op_nxt;
      lat_trap      <= lat_trap_nxt;
      req_ready     <= req_ready_nxt;
      csr_re        <= csr_re_nxt;
      csr_we        <= csr_we_nxt;
      csr_num       <= csr_num_nxt;
      csr_wmask     <= csr_wmask_nxt;
      csr_wvalue    <= csr_wvalue_nxt;
      wb_ex         <= wb_ex_nxt;
      wb_ecode      <= wb_ecode_nxt;
      wb_esubcode   <= wb_esubcode_nxt;
      wb_pc         <= wb_pc_nxt;
      wb_vaddr      <= wb_vaddr_nxt;
      ertn_flush    <= ertn_flush_nxt;
      resp_valid    <= resp_valid_nxt;
      resp_rd_wdata <= resp_rd_wdata_nxt;
      flush         <= flush_nxt;
      flush_target  <= flush_target_nxt;
    end
  end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 resetn  in  1  synchronous, active-low reset.
REQ-003 req_valid/req_ready  in/out  1/1  commit-request handshake; transfer when both high.
REQ-004 req_op  in  3  0 nop, 1 csrrd, 2 csrwr, 3 csrxchg, 4 ertn, 5 syscall, 6 break, 7 reserved (treated as INE).
REQ-005 req_csr_num  in  14; req_rd_value  in  32 (write data); req_rj_value  in  32 (xchg mask); req_pc  in  32; req_vaddr  in  32.
REQ-006 req_ex  in  1; req_ecode  in  6; req_esubcode  in  9  upstream exception tagged on request.
REQ-007 csr_re, csr_we  out  1; csr_num  out  14; csr_wmask, csr_wvalue  out  32; csr_rvalue  in  32  CSR-file access port, read combinational.
REQ-008 wb_ex  out  1; wb_ecode  out  6; wb_esubcode  out  9; wb_pc, wb_vaddr  out  32; ertn_flush  out  1  CSR-file trap/return controls.
REQ-009 csr_estat_is, csr_ecfg_lie  in  13; csr_crmd_ie  in  1; csr_crmd_plv  in  2; csr_era, csr_eentry  in  32  CSR state taps.
REQ-010 resp_valid/resp_ready  out/in  1/1; resp_rd_wdata  out  32  register-writeback result handshake.
REQ-011 flush  out  1; flush_target  out  32  pipeline redirect.

Function
REQ-012 FSM states IDLE, ACT, RESP, FLUSH; req_ready=1 only in IDLE.
REQ-013 On transfer, latch all req_* fields and int_pending = csr_crmd_ie & |(csr_estat_is & csr_ecfg_lie); go to ACT.
REQ-014 Trap priority in ACT: int_pending (ecode 0x0, esub 0) > req_ex (req_ecode/esubcode) > reserved op (0xD INE) > syscall (0xB) > break (0xC).
REQ-015 ACT with trap: wb_ex=1 for exactly one cycle, wb_pc=latched pc, wb_vaddr=latched vaddr, csr_we=0; next FLUSH with flush_target=csr_eentry.
REQ-016 ACT with ertn, no trap: ertn_flush=1 for one cycle; next FLUSH with flush_target=csr_era sampled in FLUSH.
REQ-017 ACT with csrrd: csr_re=1, csr_we=0; capture csr_rvalue into resp_rd_wdata; next RESP.
REQ-018 ACT with csrwr: csr_re=1, csr_we=1, csr_wmask=0xFFFFFFFF, csr_wvalue=rd_value; capture old csr_rvalue; next RESP.
REQ-019 ACT with csrxchg: csr_re=1, csr_we=1, csr_wmask=rj_value, csr_wvalue=rd_value; capture old value; next RESP.
REQ-020 ACT with nop: no CSR access, return to IDLE.
REQ-021 csr_re, csr_we, wb_ex, ertn_flush asserted only in ACT; never both wb_ex and ertn_flush; never csr_we with either.
REQ-022 RESP: resp_valid=1, resp_rd_wdata stable until resp_ready; on resp_ready go IDLE.
REQ-023 FLUSH: flush=1 for exactly one cycle, then IDLE; resp_valid never asserted for trapped or ertn requests.
REQ-024 Back-to-back throughput: one csr op per 3 cycles minimum (IDLE, ACT, RESP with resp_ready high).
REQ-025 Interrupt sampled only at transfer; interrupts arriving after transfer apply to next request.

Reset
REQ-026 resetn low at a clock edge forces IDLE and drops all outputs to 0 next cycle, including mid-ACT/RESP/FLUSH; in-flight request discarded with no CSR write.
REQ-027 Latched fields reset to 0; req_ready=1 first cycle after reset release.

Configuration
REQ-028 Macro CSR_PRIV_CHECK_EN defined: csrrd/csrwr/csrxchg/ertn with latched csr_crmd_plv!=0 trap ecode 0xE (IPE), priority just below req_ex.
REQ-029 Macro absent: no privilege check; plv input ignored.

Verification
REQ-030 csrrd num 0x30, csr_rvalue 0x12345678 -> ACT csr_re=1 csr_we=0, RESP resp_rd_wdata=0x12345678.
REQ-031 csrxchg num 0x6, rj 0x0000FFFF, rd 0xAAAA5555 -> csr_wmask 0x0000FFFF, csr_wvalue 0xAAAA5555, resp = old value.
REQ-032 syscall pc 0x1C000100, eentry 0x1C008000 -> wb_ex=1 ecode 0xB wb_pc 0x1C000100; next cycle flush=1 target 0x1C008000; no resp_valid.
REQ-033 estat_is bit11=1, lie bit11=1, ie=1, csrwr request -> ecode 0x0 trap, csr_we never 1.
REQ-034 ertn, era 0x1C000204 -> ertn_flush one cycle, then flush target 0x1C000204; resetn low during RESP -> next cycle IDLE, resp_valid=0.
REQ-035 With CSR_PRIV_CHECK_EN, plv=3 csrwr -> ecode 0xE, no write; without macro same stimulus performs write.
